xt_hb_arbiter: RTL and testbench

//  Shares the single XT_HB slave domain between MASTER_NUM bus masters (core LSU, debug, DMA).

---
 rtl/xt_hb_arbiter_pkg.sv | 18 +
 rtl/xt_hb_arbiter_rr_picker.sv | 36 +++
 rtl/xt_hb_arbiter.sv | 167 ++++++++++++++++
 tb/tb_xt_hb_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xt_hb_arbiter_pkg.sv
// Shared types for the XT_HB bus: strobe and slave bundles plus the arbiter FSM encoding.
package xt_hb_arbiter_pkg;

    localparam int HB_ARB_MAX_MASTERS = 8;

    typedef enum logic {HB_ARB_IDLE, HB_ARB_XFER} hb_arb_state_e;

    typedef struct packed {
        logic ren;
        logic wen;
    } sel_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
    } hb_slave_t;

endpackage

// File: rtl/xt_hb_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module xt_rr_picker #(
    parameter int N = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          valid
);

    localparam logic [2*N-1:0] ONE = 1;

    logic [N-1:0]   mask;
    logic [2*N-1:0] dbl_req;
    logic [2*N-1:0] dbl_gnt;

    // Lower half holds only requesters at/after ptr; upper half supplies the wrap-around.
    always_comb begin
        mask = '0;
        for (int i = 0; i < N; i++) begin
            mask[i] = (i >= int'(ptr));
        end
        dbl_req = {req, req & mask};
        dbl_gnt = dbl_req & ~(dbl_req - ONE);
        grant   = dbl_gnt[N-1:0] | dbl_gnt[2*N-1:N];
        idx     = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) idx = IW'(i);
        end
    end

    assign valid = |req;

endmodule

// File: rtl/xt_hb_arbiter.sv
// Round-robin arbiter sharing the XT_HB slave domain among MASTER_NUM masters, one transaction at a time.
module xt_hb_arbiter
    import xt_hb_arbiter_pkg::*;
#(
    parameter int MASTER_NUM = 2,
    parameter int TIMEOUT    = 15
) (
    input  logic                       hb_clk,
    input  logic                       hb_rst_n,
    input  sel_t      [MASTER_NUM-1:0] m_sel,
    input  hb_slave_t [MASTER_NUM-1:0] m_hb,
    output logic      [MASTER_NUM-1:0] m_grant,
    output logic      [MASTER_NUM-1:0] m_rdone,
    output logic      [MASTER_NUM-1:0] m_wdone,
    output logic      [MASTER_NUM-1:0] m_err,
    output logic      [31:0]           m_rdata,
    input  logic                       read_finish,
    input  logic                       write_finish,
    input  logic      [31:0]           rdata,
    output hb_slave_t                  xt_hb,
    output sel_t                       sel,
    output hb_arb_state_e              dbg_state
);

    // Handshake: a master raises ren/wen with m_hb stable and holds it until its
    // m_rdone/m_wdone/m_err pulse; a request seen in the pulse cycle is a new request.

    localparam int IW = $clog2(MASTER_NUM);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

    if (MASTER_NUM < 2 || MASTER_NUM > HB_ARB_MAX_MASTERS) begin : g_bad_masters
        $error("xt_hb_arbiter: MASTER_NUM out of range");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("xt_hb_arbiter: TIMEOUT out of range");
    end

    hb_arb_state_e           state, state_n;
    logic [IW-1:0]           ptr, ptr_n, owner, owner_n, next_ptr;
    logic [MASTER_NUM-1:0]   grant_q, grant_n, rdone_n, wdone_n, err_n;
    logic [MASTER_NUM-1:0]   rdone_q, wdone_q, err_q, req;
    logic                    op_r, op_r_n, op_w, op_w_n;
    logic                    need_r, need_r_n, need_w, need_w_n;
    logic [TW-1:0]           tcnt, tcnt_n;
    logic [31:0]             rdata_q, rdata_n;
    logic [MASTER_NUM-1:0]   pick_grant;
    logic [IW-1:0]           pick_idx;
    logic                    pick_valid;

    always_comb begin
        for (int i = 0; i < MASTER_NUM; i++) begin
            req[i] = m_sel[i].ren | m_sel[i].wen;
        end
    end

    xt_rr_picker #(.N(MASTER_NUM)) u_picker (
        .req   (req),
        .ptr   (ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    assign next_ptr = (owner == IW'(MASTER_NUM - 1)) ? '0 : owner + IW'(1);

    always_comb begin
        state_n  = state;
        ptr_n    = ptr;
        owner_n  = owner;
        grant_n  = grant_q;
        op_r_n   = op_r;
        op_w_n   = op_w;
        need_r_n = need_r;
        need_w_n = need_w;
        tcnt_n   = tcnt;
        rdata_n  = rdata_q;
        rdone_n  = '0;
        wdone_n  = '0;
        err_n    = '0;
        sel      = '0;
        xt_hb    = '0;
        case (state)
            HB_ARB_IDLE: begin
                if (pick_valid) begin
                    state_n  = HB_ARB_XFER;
                    owner_n  = pick_idx;
                    grant_n  = pick_grant;
                    op_r_n   = m_sel[pick_idx].ren;
                    op_w_n   = m_sel[pick_idx].wen;
                    need_r_n = m_sel[pick_idx].ren;
                    need_w_n = m_sel[pick_idx].wen;
                    tcnt_n   = '0;
                end
            end
            HB_ARB_XFER: begin
                xt_hb   = m_hb[owner];
                // Dropping ren as soon as read_finish shows lets the domain's flag self-clear.
                sel.ren = need_r & ~read_finish;
                sel.wen = need_w;
                if (need_r && read_finish) begin
                    rdata_n  = rdata;
                    need_r_n = 1'b0;
                end
                if (need_w && write_finish) begin
                    need_w_n = 1'b0;
                end
                if (tcnt != TMAX) tcnt_n = tcnt + TW'(1);
                if (!need_r_n && !need_w_n) begin
                    state_n        = HB_ARB_IDLE;
                    grant_n        = '0;
                    ptr_n          = next_ptr;
                    rdone_n[owner] = op_r;
                    wdone_n[owner] = op_w;
                end else if (tcnt == TMAX) begin
                    state_n      = HB_ARB_IDLE;
                    grant_n      = '0;
                    ptr_n        = next_ptr;
                    need_r_n     = 1'b0;
                    need_w_n     = 1'b0;
                    err_n[owner] = 1'b1;
                end
            end
            default: state_n = HB_ARB_IDLE;
        endcase
    end

    always_ff @(posedge hb_clk or negedge hb_rst_n) begin
        if (!hb_rst_n) begin
            state   <= HB_ARB_IDLE;
            ptr     <= '0;
            owner   <= '0;
            grant_q <= '0;
            op_r    <= 1'b0;
            op_w    <= 1'b0;
            need_r  <= 1'b0;
            need_w  <= 1'b0;
            tcnt    <= '0;
            rdata_q <= '0;
            rdone_q <= '0;
            wdone_q <= '0;
            err_q   <= '0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            owner   <= owner_n;
            grant_q <= grant_n;
            op_r    <= op_r_n;
            op_w    <= op_w_n;
            need_r  <= need_r_n;
            need_w  <= need_w_n;
            tcnt    <= tcnt_n;
            rdata_q <= rdata_n;
            rdone_q <= rdone_n;
            wdone_q <= wdone_n;
            err_q   <= err_n;
        end
    end

    assign m_grant   = grant_q;
    assign m_rdone   = rdone_q;
    assign m_wdone   = wdone_q;
    assign m_err     = err_q;
    assign m_rdata   = rdata_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_xt_hb_arbiter.sv
// Bench for xt_hb_arbiter with two masters and a small XT_HB domain model.
module tb_xt_hb_arbiter;
    import xt_hb_arbiter_pkg::*;

    localparam int M  = 2;
    localparam int EW = 38;

    typedef struct {
        int          m;
        bit          ren;
        bit          wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          grant_lat;
        int          done_lat;
    } vec_t;

    logic                hb_clk = 1'b0;
    logic                hb_rst_n;
    sel_t      [M-1:0]   m_sel;
    hb_slave_t [M-1:0]   m_hb;
    logic      [M-1:0]   m_grant, m_rdone, m_wdone, m_err;
    logic      [31:0]    m_rdata, rdata;
    logic                read_finish, write_finish;
    hb_slave_t           xt_hb;
    sel_t                sel;
    hb_arb_state_e       dbg_state;

    logic [M-1:0]        ren_hold, wen_hold;
    logic                dom_dead;
    logic [EW-1:0]       exp_q[$];
    logic [M-1:0]        grant_log[$];
    logic [M-1:0]        prev_grant;
    int                  n_cmp, n_err, cyc, viol, err_seen;
    bit                  auto_rel;
    vec_t                vecs[6];

    xt_hb_arbiter #(.MASTER_NUM(M), .TIMEOUT(15)) dut (
        .hb_clk       (hb_clk),
        .hb_rst_n     (hb_rst_n),
        .m_sel        (m_sel),
        .m_hb         (m_hb),
        .m_grant      (m_grant),
        .m_rdone      (m_rdone),
        .m_wdone      (m_wdone),
        .m_err        (m_err),
        .m_rdata      (m_rdata),
        .read_finish  (read_finish),
        .write_finish (write_finish),
        .rdata        (rdata),
        .xt_hb        (xt_hb),
        .sel          (sel),
        .dbg_state    (dbg_state)
    );

    always #5 hb_clk = ~hb_clk;

    // Masters drop their request in the cycle their done/err pulse is visible.
    always_comb begin
        m_sel = '0;
        for (int i = 0; i < M; i++) begin
            m_sel[i].ren = ren_hold[i] & ~(m_rdone[i] | m_wdone[i] | m_err[i]);
            m_sel[i].wen = wen_hold[i] & ~(m_rdone[i] | m_wdone[i] | m_err[i]);
        end
    end

    function automatic logic [31:0] dom_data(input logic [31:0] a);
        return 32'hA5A5_0000 + ((a - 32'h10) >> 2);
    endfunction

    // Domain model: registered read_finish/rdata, same-cycle write_finish.
    always @(posedge hb_clk or negedge hb_rst_n) begin
        if (!hb_rst_n) begin
            read_finish <= 1'b0;
            rdata       <= '0;
        end else begin
            read_finish <= sel.ren & ~dom_dead;
            if (sel.ren) rdata <= dom_data(xt_hb.addr);
        end
    end
    assign write_finish = sel.wen & ~dom_dead;

    function automatic logic [EW-1:0] ev(input int m, input logic r, input logic w,
                                         input logic e, input logic [31:0] d);
        return {3'(m), r, w, e, d};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        logic [EW-1:0] got;
        @(negedge hb_clk);
        cyc++;
        if (sel.ren && read_finish) viol++;
        for (int m = 0; m < M; m++) begin
            if (m_rdone[m] | m_wdone[m] | m_err[m]) begin
                got = ev(m, m_rdone[m], m_wdone[m], m_err[m], m_rdone[m] ? m_rdata : 32'h0);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb_unexpected: got %0h expected none", got);
                end else begin
                    chk("sb_event", 64'(got), 64'(exp_q.pop_front()));
                end
                if (m_err[m]) err_seen++;
                if (auto_rel) begin
                    ren_hold[m] = 1'b0;
                    wen_hold[m] = 1'b0;
                end
            end
        end
        if (m_grant != '0 && prev_grant == '0) grant_log.push_back(m_grant);
        prev_grant = m_grant;
    endtask

    task automatic issue(input int m, input bit r, input bit w, input logic [31:0] a,
                         input logic [31:0] d, input bit push);
        m_hb[m].addr  = a;
        m_hb[m].wdata = d;
        ren_hold[m]   = r;
        wen_hold[m]   = w;
        if (push) exp_q.push_back(ev(m, r, w, 1'b0, r ? dom_data(a) : 32'h0));
    endtask

    task automatic wait_grant(input int m, output int at);
        at = -1;
        for (int k = 0; k < 40 && at < 0; k++) begin
            step();
            if (m_grant[m]) at = cyc;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int t0, g, d;
        issue(v.m, v.ren, v.wen, v.addr, v.wdata, 1'b1);
        t0 = cyc;
        g  = -1;
        d  = -1;
        for (int k = 0; k < 40 && d < 0; k++) begin
            step();
            if (g < 0 && m_grant[v.m]) begin
                g = cyc - t0;
                chk("vec_sel_ren", sel.ren, v.ren);
                chk("vec_sel_wen", sel.wen, v.wen);
                chk("vec_xt_addr", xt_hb.addr, v.addr);
                chk("vec_xt_wdata", xt_hb.wdata, v.wdata);
            end
            if (m_rdone[v.m] | m_wdone[v.m]) begin
                d = cyc - t0;
                if (v.ren && v.wen) chk("vec_both_pulse", {m_rdone[v.m], m_wdone[v.m]}, 2'b11);
            end
        end
        chk("vec_grant_lat", g, v.grant_lat);
        chk("vec_done_lat", d, v.done_lat);
        step();
    endtask

    initial begin
        int g, e, wd, n, e0, t0;
        logic [31:0] prev;
        vec_t v;

        vecs[0] = '{0, 1'b0, 1'b1, 32'h100, 32'h1111_2222, 1, 2};
        vecs[1] = '{1, 1'b1, 1'b0, 32'h44,  32'h0,         1, 3};
        vecs[2] = '{1, 1'b1, 1'b1, 32'h48,  32'hDEAD_BEEF, 1, 3};
        vecs[3] = '{0, 1'b1, 1'b1, 32'h1C,  32'h0BAD_F00D, 1, 3};
        vecs[4] = '{1, 1'b0, 1'b1, 32'h200, 32'h3333,      1, 2};
        vecs[5] = '{0, 1'b1, 1'b0, 32'h10,  32'h0,         1, 3};

        n_cmp = 0; n_err = 0; cyc = 0; viol = 0; err_seen = 0;
        auto_rel = 1'b1; prev_grant = '0;
        hb_rst_n = 1'b0; ren_hold = '0; wen_hold = '0; m_hb = '0; dom_dead = 1'b0;

        // Reset state
        repeat (3) @(negedge hb_clk);
        chk("rst_grant", m_grant, 0);
        chk("rst_pulses", {m_rdone, m_wdone, m_err}, 0);
        chk("rst_rdata", m_rdata, 0);
        chk("rst_xt_hb", xt_hb, 0);
        chk("rst_sel", sel, 0);
        chk("rst_state", dbg_state, HB_ARB_IDLE);
        hb_rst_n = 1'b1;
        step();

        // Single read from M0
        issue(0, 1'b1, 1'b0, 32'h14, 32'h0, 1'b1);
        step();
        chk("t1_grant_c1", m_grant, 2'b01);
        chk("t1_ren_c1", sel.ren, 1'b1);
        step();
        chk("t1_ren_c2", sel.ren, 1'b0);
        chk("t1_grant_c2", m_grant, 2'b01);
        step();
        chk("t1_rdone_c3", m_rdone, 2'b01);
        chk("t1_rdata_c3", m_rdata, 32'hA5A5_0001);
        chk("t1_grant_c3", m_grant, 2'b00);
        step();

        // M1 write moves ptr back to 0, then simultaneous writes
        v = '{1, 1'b0, 1'b1, 32'h104, 32'hCAFE_0001, 1, 2};
        run_vec(v);
        issue(0, 1'b0, 1'b1, 32'h108, 32'h0000_00A0, 1'b1);
        issue(1, 1'b0, 1'b1, 32'h10C, 32'h0000_00B1, 1'b1);
        step();
        chk("t2_grant0_c1", m_grant, 2'b01);
        step();
        chk("t2_wdone0_c2", m_wdone, 2'b01);
        step();
        chk("t2_grant1_c3", m_grant, 2'b10);
        chk("t2_xt_addr_c3", xt_hb.addr, 32'h10C);
        step();
        chk("t2_wdone1_c4", m_wdone, 2'b10);
        step();

        // Both masters hold reads for 8 transactions
        auto_rel = 1'b0;
        grant_log.delete();
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back(ev(k % 2, 1'b1, 1'b0, 1'b0, dom_data((k % 2) ? 32'h30 : 32'h20)));
        end
        issue(0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
        issue(1, 1'b1, 1'b0, 32'h30, 32'h0, 1'b0);
        n = 0;
        for (int k = 0; k < 120 && n < 8; k++) begin
            step();
            if (m_rdone != '0) n++;
            if (n == 8) begin
                ren_hold = '0;
                wen_hold = '0;
            end
        end
        auto_rel = 1'b1;
        chk("t3_done_count", n, 8);
        chk("t3_grant_count", grant_log.size(), 8);
        for (int k = 0; k < 8 && k < grant_log.size(); k++) begin
            chk("t3_rr_order", grant_log[k], (k % 2) ? 2'b10 : 2'b01);
        end
        repeat (4) step();

        // Table of isolated transactions
        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Timeout with silent domain, then M1 served
        dom_dead = 1'b1;
        prev = m_rdata;
        e0 = err_seen;
        issue(0, 1'b1, 1'b0, 32'h60, 32'h0, 1'b0);
        exp_q.push_back(ev(0, 1'b0, 1'b0, 1'b1, 32'h0));
        wait_grant(0, g);
        issue(1, 1'b0, 1'b1, 32'h64, 32'h5555, 1'b1);
        e = -1;
        for (int k = 0; k < 40 && e < 0; k++) begin
            step();
            if (m_err[0]) begin
                e = cyc;
                chk("t4_rdata_kept", m_rdata, prev);
                dom_dead = 1'b0;
            end
        end
        wd = -1;
        for (int k = 0; k < 10 && wd < 0; k++) begin
            step();
            if (m_wdone[1]) wd = cyc;
        end
        chk("t4_err_delay", e - g, 16);
        chk("t4_next_served", wd - e, 2);
        repeat (3) step();
        chk("t4_err_once", err_seen - e0, 1);
        chk("t4_rdata_after", m_rdata, prev);

        // M0 write leaves ptr at 1; reset mid-XFER must clear it
        v = '{0, 1'b0, 1'b1, 32'h80, 32'h77, 1, 2};
        run_vec(v);
        dom_dead = 1'b1;
        issue(1, 1'b1, 1'b0, 32'h90, 32'h0, 1'b0);
        wait_grant(1, g);
        chk("t6_grant_seen", g >= 0, 1'b1);
        step();
        hb_rst_n = 1'b0;
        #1;
        chk("t6_sel_async", sel, 0);
        chk("t6_grant_async", m_grant, 0);
        chk("t6_xt_hb_async", xt_hb, 0);
        ren_hold = '0;
        wen_hold = '0;
        dom_dead = 1'b0;
        repeat (3) step();
        hb_rst_n = 1'b1;
        chk("t6_rdata_rst", m_rdata, 0);
        step();
        issue(0, 1'b0, 1'b1, 32'hA0, 32'h1, 1'b1);
        issue(1, 1'b0, 1'b1, 32'hA4, 32'h2, 1'b1);
        t0 = -1;
        for (int k = 0; k < 10 && t0 < 0; k++) begin
            step();
            if (m_grant != '0) begin
                t0 = cyc;
                chk("t6_first_grant", m_grant, 2'b01);
            end
        end
        chk("t6_grant_found", t0 >= 0, 1'b1);
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) step();
        repeat (3) step();

        chk("sb_drain", exp_q.size(), 0);
        chk("ren_vs_read_finish", viol, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
